// File: rtl/lsu_seg7_pkg.sv
// Shared types and constants for the LSU 7-segment display controller.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package lsu_seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    typedef enum logic [1:0] {
        SEG7_HEX  = 2'b00,
        SEG7_UDEC = 2'b01,
        SEG7_SDEC = 2'b10
    } seg7_mode_e;

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StLoad
    } seg7_state_e;

    function automatic logic [6:0] seg_of_nibble(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    // Decimal digits needed for an unsigned w-bit value: floor(w*log10(2)) + 1.
    function automatic int unsigned bcd_digits(input int unsigned w);
        return (w * 30103) / 100000 + 1;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lsu_seg7_bcd_conv.sv
// Sequential double-dabble binary-to-BCD converter, one magnitude bit per cycle.
// o_done is high during the cycle in which the final shift is applied.
module lsu_seg7_bcd_conv
    import lsu_seg7_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned BCD_DIGITS = bcd_digits(DATA_W)
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_start,
    input  logic [DATA_W-1:0]       i_mag,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [4*BCD_DIGITS-1:0] o_bcd
);

    localparam int unsigned BCD_W = 4 * BCD_DIGITS;
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] r_mag;
    logic [BCD_W-1:0]  r_bcd;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;
    logic [BCD_W-1:0]  w_adj;

    always_comb begin
        w_adj = r_bcd;
        for (int unsigned k = 0; k < BCD_DIGITS; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5) begin
                w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
            end
        end
    end

    assign o_done = r_busy && (r_cnt == CNT_W'(DATA_W - 1));
    assign o_busy = r_busy;
    assign o_bcd  = r_bcd;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_mag  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_mag  <= i_mag;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_bcd <= {w_adj[BCD_W-2:0], r_mag[DATA_W-1]};
            r_mag <= r_mag << 1;
            r_cnt <= r_cnt + 1'b1;
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/lsu_seg7_ctrl.sv
// Multi-digit 7-segment controller: hex renders in the accepting cycle, decimal
// goes through the BCD converter. Rendering, sign placement and blanking live here.
module lsu_seg7_ctrl
    import lsu_seg7_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned NUM_DIGITS = 8
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [DATA_W-1:0]       i_data,
    input  logic [1:0]              i_mode,
    input  logic                    i_blank_lz,
    output logic [7*NUM_DIGITS-1:0] o_seg,
    output logic                    o_done,
    output logic                    o_ovf
);

    localparam int unsigned HEX_DIGITS = DATA_W / 4;
    localparam int unsigned BCD_DIGITS = bcd_digits(DATA_W);
    localparam int unsigned PAD_DIGITS = max_u(max_u(HEX_DIGITS, BCD_DIGITS), NUM_DIGITS);
    localparam int unsigned PAD_W      = 4 * PAD_DIGITS;

    seg7_state_e              r_state;
    logic                     r_sign;
    logic                     r_blank_lz;

    seg7_mode_e               w_mode;
    logic                     w_is_dec;
    logic                     w_start;
    logic [DATA_W-1:0]        w_mag;
    logic                     w_conv_busy;
    logic                     w_conv_done;
    logic [4*BCD_DIGITS-1:0]  w_bcd;

    logic [PAD_W-1:0]         w_digits;
    logic                     w_sign;
    logic                     w_blank_lz;
    int unsigned              w_msd;
    int unsigned              w_need;
    logic                     w_ovf;
    logic [7*NUM_DIGITS-1:0]  w_seg;

    assign o_ready  = (r_state == StIdle);
    assign w_mode   = seg7_mode_e'(i_mode);
    assign w_is_dec = (w_mode == SEG7_UDEC) || (w_mode == SEG7_SDEC);
    assign w_start  = i_valid && o_ready && w_is_dec;
    assign w_mag    = ((w_mode == SEG7_SDEC) && i_data[DATA_W-1]) ? (~i_data + 1'b1) : i_data;

    lsu_seg7_bcd_conv #(
        .DATA_W     (DATA_W),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_bcd_conv (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_start (w_start),
        .i_mag   (w_mag),
        .o_busy  (w_conv_busy),
        .o_done  (w_conv_done),
        .o_bcd   (w_bcd)
    );

    // One renderer serves both paths: live hex input while idle, BCD result in LOAD.
    assign w_digits   = (r_state == StLoad) ? PAD_W'(w_bcd) : PAD_W'(i_data);
    assign w_sign     = (r_state == StLoad) && r_sign;
    assign w_blank_lz = (r_state == StLoad) ? r_blank_lz : i_blank_lz;

    always_comb begin
        w_msd = 0;
        for (int unsigned k = 0; k < PAD_DIGITS; k++) begin
            if (w_digits[4*k +: 4] != 4'd0) begin
                w_msd = k;
            end
        end
        w_need = w_msd + 32'(w_sign) + 32'd1;
        w_ovf  = (w_need > NUM_DIGITS);
        w_seg  = '1;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (w_ovf) begin
                w_seg[7*k +: 7] = SEG_MINUS;
            end else if (w_sign && ((w_blank_lz && (k == w_msd + 1)) ||
                                    (!w_blank_lz && (k == NUM_DIGITS - 1)))) begin
                w_seg[7*k +: 7] = SEG_MINUS;
            end else if (w_blank_lz && (k > w_msd)) begin
                w_seg[7*k +: 7] = SEG_BLANK;
            end else begin
                w_seg[7*k +: 7] = seg_of_nibble(w_digits[4*k +: 4]);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_sign     <= 1'b0;
            r_blank_lz <= 1'b0;
            o_seg      <= '1;
            o_done     <= 1'b0;
            o_ovf      <= 1'b0;
        end else begin
            o_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_valid) begin
                        if (w_is_dec) begin
                            r_sign     <= (w_mode == SEG7_SDEC) && i_data[DATA_W-1];
                            r_blank_lz <= i_blank_lz;
                            r_state    <= StConv;
                        end else begin
                            o_seg  <= w_seg;
                            o_ovf  <= w_ovf;
                            o_done <= 1'b1;
                        end
                    end
                end
                StConv: begin
                    if (w_conv_done) begin
                        r_state <= StLoad;
                    end else if (!w_conv_busy) begin
                        // Converter lost its job; never stall the port.
                        r_state <= StIdle;
                    end
                end
                StLoad: begin
                    o_seg   <= w_seg;
                    o_ovf   <= w_ovf;
                    o_done  <= 1'b1;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_seg7_ctrl.sv
// Directed bench for lsu_seg7_ctrl (DATA_W=32, NUM_DIGITS=8) with hand-computed
// segment patterns.
module tb_lsu_seg7_ctrl;

    localparam logic [6:0] K0  = 7'b1000000;
    localparam logic [6:0] K1  = 7'b1111001;
    localparam logic [6:0] K2  = 7'b0100100;
    localparam logic [6:0] K3  = 7'b0110000;
    localparam logic [6:0] K4  = 7'b0011001;
    localparam logic [6:0] K5  = 7'b0010010;
    localparam logic [6:0] K6  = 7'b0000010;
    localparam logic [6:0] K7  = 7'b1111000;
    localparam logic [6:0] K8  = 7'b0000000;
    localparam logic [6:0] K9  = 7'b0010000;
    localparam logic [6:0] KA  = 7'b0001000;
    localparam logic [6:0] KB  = 7'b0000011;
    localparam logic [6:0] KD  = 7'b0100001;
    localparam logic [6:0] KE  = 7'b0000110;
    localparam logic [6:0] KF  = 7'b0001110;
    localparam logic [6:0] KBL = 7'b1111111;
    localparam logic [6:0] KMI = 7'b0111111;

    logic        clk;
    logic        i_reset;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_data;
    logic [1:0]  i_mode;
    logic        i_blank_lz;
    logic [55:0] o_seg;
    logic        o_done;
    logic        o_ovf;

    int n_tests = 0;
    int n_fail  = 0;
    int n_cyc;
    int n_dones;

    lsu_seg7_ctrl #(
        .DATA_W     (32),
        .NUM_DIGITS (8)
    ) u_dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_data     (i_data),
        .i_mode     (i_mode),
        .i_blank_lz (i_blank_lz),
        .o_seg      (o_seg),
        .o_done     (o_done),
        .o_ovf      (o_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic [1:0] m, input logic bl);
        i_data     = d;
        i_mode     = m;
        i_blank_lz = bl;
        i_valid    = 1'b1;
        tick();
        i_valid    = 1'b0;
    endtask

    // Waits (bounded) for o_ready; counts edges and any o_done seen while busy.
    task automatic wait_ready(output int n, output int dones);
        n     = 0;
        dones = 0;
        while (!o_ready && n < 100) begin
            tick();
            n++;
            if (!o_ready && o_done) dones++;
        end
    endtask

    initial begin
        i_reset    = 1'b1;
        i_valid    = 1'b0;
        i_data     = '0;
        i_mode     = 2'b00;
        i_blank_lz = 1'b0;
        tick();
        tick();
        check_eq("rst_seg",   64'(o_seg),   64'({8{KBL}}));
        check_eq("rst_ready", 64'(o_ready), 64'd1);
        check_eq("rst_done",  64'(o_done),  64'd0);
        check_eq("rst_ovf",   64'(o_ovf),   64'd0);
        i_reset = 1'b0;
        tick();

        // Hex, blanked, updates on the accepting edge
        send(32'h0000BEEF, 2'b00, 1'b1);
        check_eq("hex_beef_seg",  64'(o_seg), 64'({KBL, KBL, KBL, KBL, KB, KE, KE, KF}));
        check_eq("hex_beef_done", 64'(o_done), 64'd1);
        check_eq("hex_beef_ovf",  64'(o_ovf), 64'd0);
        check_eq("hex_beef_rdy",  64'(o_ready), 64'd1);
        tick();
        check_eq("hex_beef_done_off", 64'(o_done), 64'd0);

        // Mode 11 is hex, no blanking
        send(32'hDEADBEEF, 2'b11, 1'b0);
        check_eq("hex_mode3_seg", 64'(o_seg), 64'({KD, KE, KA, KD, KB, KE, KE, KF}));

        // Back-to-back hex, one per cycle
        i_valid = 1'b1; i_mode = 2'b00; i_blank_lz = 1'b0; i_data = 32'h00000012;
        tick();
        check_eq("hex_b2b_a", 64'(o_seg), 64'({K0, K0, K0, K0, K0, K0, K1, K2}));
        i_data = 32'h00000034;
        tick();
        check_eq("hex_b2b_b", 64'(o_seg), 64'({K0, K0, K0, K0, K0, K0, K3, K4}));
        check_eq("hex_b2b_done", 64'(o_done), 64'd1);
        i_valid = 1'b0;
        tick();

        // Unsigned decimal, no blanking; latency 33 edges, display held meanwhile
        send(32'd12345678, 2'b01, 1'b0);
        check_eq("udec_rdy_low", 64'(o_ready), 64'd0);
        check_eq("udec_hold", 64'(o_seg), 64'({K0, K0, K0, K0, K0, K0, K3, K4}));
        wait_ready(n_cyc, n_dones);
        check_eq("udec_latency", 64'(n_cyc), 64'd33);
        check_eq("udec_early_done", 64'(n_dones), 64'd0);
        check_eq("udec_seg", 64'(o_seg), 64'({K1, K2, K3, K4, K5, K6, K7, K8}));
        check_eq("udec_done", 64'(o_done), 64'd1);
        check_eq("udec_ovf", 64'(o_ovf), 64'd0);
        tick();
        check_eq("udec_done_off", 64'(o_done), 64'd0);

        // Signed -42, blanked: minus just above the MSD
        send(32'hFFFFFFD6, 2'b10, 1'b1);
        wait_ready(n_cyc, n_dones);
        check_eq("sdec_m42_seg", 64'(o_seg), 64'({KBL, KBL, KBL, KBL, KBL, KMI, K4, K2}));
        check_eq("sdec_m42_ovf", 64'(o_ovf), 64'd0);

        // Signed -1, unblanked: minus in the top digit
        send(32'hFFFFFFFF, 2'b10, 1'b0);
        wait_ready(n_cyc, n_dones);
        check_eq("sdec_m1_seg", 64'(o_seg), 64'({KMI, K0, K0, K0, K0, K0, K0, K1}));

        // Largest fits: 8 unsigned digits, 7 digits plus sign
        send(32'd99999999, 2'b01, 1'b1);
        wait_ready(n_cyc, n_dones);
        check_eq("udec_max_seg", 64'(o_seg), 64'({8{K9}}));
        check_eq("udec_max_ovf", 64'(o_ovf), 64'd0);
        send(-32'sd9999999, 2'b10, 1'b1);
        wait_ready(n_cyc, n_dones);
        check_eq("sdec_max_seg", 64'(o_seg), 64'({KMI, K9, K9, K9, K9, K9, K9, K9}));
        check_eq("sdec_max_ovf", 64'(o_ovf), 64'd0);

        // Overflows
        send(32'd100000000, 2'b01, 1'b1);
        wait_ready(n_cyc, n_dones);
        check_eq("ovf_u_seg", 64'(o_seg), 64'({8{KMI}}));
        check_eq("ovf_u_flag", 64'(o_ovf), 64'd1);
        send(-32'sd12345678, 2'b10, 1'b1);
        wait_ready(n_cyc, n_dones);
        check_eq("ovf_s9_flag", 64'(o_ovf), 64'd1);
        send(32'h80000000, 2'b10, 1'b1);
        wait_ready(n_cyc, n_dones);
        check_eq("ovf_smin_seg", 64'(o_seg), 64'({8{KMI}}));
        check_eq("ovf_smin_flag", 64'(o_ovf), 64'd1);

        // Reset 10 cycles into a conversion
        send(32'd5555, 2'b01, 1'b1);
        for (int i = 0; i < 9; i++) tick();
        i_reset = 1'b1;
        #1;
        check_eq("mid_rst_seg",   64'(o_seg),   64'({8{KBL}}));
        check_eq("mid_rst_ready", 64'(o_ready), 64'd1);
        check_eq("mid_rst_ovf",   64'(o_ovf),   64'd0);
        tick();
        i_reset = 1'b0;
        n_dones = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (o_done) n_dones++;
        end
        check_eq("mid_rst_no_done", 64'(n_dones), 64'd0);
        check_eq("mid_rst_seg_held", 64'(o_seg), 64'({8{KBL}}));
        send(32'd7, 2'b01, 1'b1);
        wait_ready(n_cyc, n_dones);
        check_eq("post_rst_lat", 64'(n_cyc), 64'd33);
        check_eq("post_rst_seg", 64'(o_seg), 64'({KBL, KBL, KBL, KBL, KBL, KBL, KBL, K7}));

        // Overflow flag clears on next request; zero shows "0"
        send(32'd100000000, 2'b01, 1'b0);
        wait_ready(n_cyc, n_dones);
        send(32'h00000000, 2'b00, 1'b1);
        check_eq("hex0_ovf", 64'(o_ovf), 64'd0);
        check_eq("hex0_seg", 64'(o_seg), 64'({KBL, KBL, KBL, KBL, KBL, KBL, KBL, K0}));
        tick();

        // i_valid held through CONV with new data: only first shown, second taken later
        i_data = 32'd123; i_mode = 2'b01; i_blank_lz = 1'b1; i_valid = 1'b1;
        tick();
        check_eq("hold_rdy_low", 64'(o_ready), 64'd0);
        i_data = 32'd456;
        wait_ready(n_cyc, n_dones);
        check_eq("hold_lat", 64'(n_cyc), 64'd33);
        check_eq("hold_first_seg", 64'(o_seg), 64'({KBL, KBL, KBL, KBL, KBL, K1, K2, K3}));
        tick();
        check_eq("hold_second_acc", 64'(o_ready), 64'd0);
        i_valid = 1'b0;
        wait_ready(n_cyc, n_dones);
        check_eq("hold_second_seg", 64'(o_seg), 64'({KBL, KBL, KBL, KBL, KBL, K4, K5, K6}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
